// File: rtl/axi4_lite_timer_pkg.sv
// Timer slave constants: register offsets, response codes, bus FSM states
// and the register-write request handed from the bus logic to the core.
package axi4_lite_timer_pkg;

  // Interconnect slot for this slave
  localparam int          TIMER_SLAVE_NUM = 3;
  localparam logic [31:0] TIMER_BASE      = 32'h4000_1000;
  localparam logic [31:0] TIMER_MASK      = 32'hFFFF_FFE0;

  // Register byte offsets
  localparam logic [4:0] TIMER_CTRL_OFF     = 5'h00;
  localparam logic [4:0] TIMER_STATUS_OFF   = 5'h04;
  localparam logic [4:0] TIMER_COUNT_OFF    = 5'h08;
  localparam logic [4:0] TIMER_COMPARE_OFF  = 5'h0C;
  localparam logic [4:0] TIMER_PRESCALE_OFF = 5'h10;

  // Word indices as decoded from addr[4:2]
  localparam logic [2:0] IDX_CTRL     = TIMER_CTRL_OFF[4:2];
  localparam logic [2:0] IDX_STATUS   = TIMER_STATUS_OFF[4:2];
  localparam logic [2:0] IDX_COUNT    = TIMER_COUNT_OFF[4:2];
  localparam logic [2:0] IDX_COMPARE  = TIMER_COMPARE_OFF[4:2];
  localparam logic [2:0] IDX_PRESCALE = TIMER_PRESCALE_OFF[4:2];

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rd_state_t;

  // One accepted register write, valid for exactly the acceptance cycle
  typedef struct packed {
    logic        en;
    logic [2:0]  idx;
    logic [31:0] data;
    logic [3:0]  strb;
  } reg_wr_t;

  function automatic logic idx_mapped(input logic [2:0] idx);
    return idx <= IDX_PRESCALE;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_timer_if.sv
// AXI4-Lite bus bundle for the timer slave port.
interface axi4_lite_timer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid, awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid, wready;
  logic [1:0]              bresp;
  logic                    bvalid, bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid, arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid, rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_timer_core.sv
// Timer datapath: CTRL, STATUS match flag, COUNT, COMPARE, PRESCALE and the
// prescale counter. Register writes arrive as one-cycle requests.
module axi4_lite_timer_core
  import axi4_lite_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  reg_wr_t     wr,
  output logic [2:0]  ctrl,
  output logic        match_flag,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic [15:0] prescale
);

  logic [2:0]  ctrl_q, ctrl_d;
  logic        flag_q, flag_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        tick, hit;

  // ctrl[0]=enable, ctrl[1]=auto_reload, ctrl[2]=irq_en
  assign tick = ctrl_q[0] && (pcnt_q == prescale_q);
  assign hit  = tick && (count_q == compare_q);

  // Next-state: counting first, then software writes override, match set last
  always_comb begin
    ctrl_d     = ctrl_q;
    flag_d     = flag_q;
    count_d    = count_q;
    compare_d  = compare_q;
    prescale_d = prescale_q;
    pcnt_d     = (!ctrl_q[0] || tick) ? 16'd0 : pcnt_q + 16'd1;
    if (tick) count_d = (hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
    if (wr.en) begin
      case (wr.idx)
        IDX_CTRL:    if (wr.strb[0]) ctrl_d = wr.data[2:0];
        IDX_STATUS:  if (wr.strb[0] && wr.data[0]) flag_d = 1'b0;
        IDX_COUNT:   count_d   = merge_bytes(count_q, wr.data, wr.strb);
        IDX_COMPARE: compare_d = merge_bytes(compare_q, wr.data, wr.strb);
        IDX_PRESCALE: begin
          if (wr.strb[0]) prescale_d[7:0]  = wr.data[7:0];
          if (wr.strb[1]) prescale_d[15:8] = wr.data[15:8];
          pcnt_d = 16'd0;
        end
        default: ;
      endcase
    end
    if (hit) flag_d = 1'b1;
  end

  // Register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      flag_q     <= 1'b0;
      count_q    <= '0;
      compare_q  <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      flag_q     <= flag_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign ctrl       = ctrl_q;
  assign match_flag = flag_q;
  assign count      = count_q;
  assign compare    = compare_q;
  assign prescale   = prescale_q;

endmodule

// File: rtl/axi4_lite_timer.sv
// AXI4-Lite timer/compare slave: independent write and read responders in
// front of the timer core, plus the level interrupt.
module axi4_lite_timer
  import axi4_lite_timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  axi4_lite_timer_if.slave  bus,
  output logic              irq
);

  wr_state_t             w_state_q;
  rd_state_t             r_state_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_val;
  logic [2:0]            aw_idx, ar_idx;
  logic                  aw_hs, ar_hs;
  reg_wr_t               reg_wr;

  logic [2:0]  ctrl;
  logic        match_flag;
  logic [31:0] count, compare;
  logic [15:0] prescale;

  // Upper address bits were already decoded by the interconnect
  logic unused_addr;
  assign unused_addr = ^{bus.awaddr[ADDR_WIDTH-1:5], bus.awaddr[1:0],
                         bus.araddr[ADDR_WIDTH-1:5], bus.araddr[1:0]};

  assign aw_idx = bus.awaddr[4:2];
  assign ar_idx = bus.araddr[4:2];

  // Address and data are only ever taken together; readies drop during reset
  assign aw_hs       = (w_state_q == W_IDLE) && bus.awvalid && bus.wvalid && !rst;
  assign bus.awready = aw_hs;
  assign bus.wready  = aw_hs;
  assign bus.arready = (r_state_q == R_IDLE) && !rst;
  assign ar_hs       = bus.arready && bus.arvalid;

  assign reg_wr.en   = aw_hs && idx_mapped(aw_idx);
  assign reg_wr.idx  = aw_idx;
  assign reg_wr.data = bus.wdata;
  assign reg_wr.strb = bus.wstrb;

  axi4_lite_timer_core u_core (
    .clk        (clk),
    .rst        (rst),
    .wr         (reg_wr),
    .ctrl       (ctrl),
    .match_flag (match_flag),
    .count      (count),
    .compare    (compare),
    .prescale   (prescale)
  );

  // Read data mux over the pre-edge register state
  always_comb begin
    rd_val = '0;
    case (ar_idx)
      IDX_CTRL:     rd_val[2:0]  = ctrl;
      IDX_STATUS:   rd_val[0]    = match_flag;
      IDX_COUNT:    rd_val       = count;
      IDX_COMPARE:  rd_val       = compare;
      IDX_PRESCALE: rd_val[15:0] = prescale;
      default:      rd_val       = '0;
    endcase
  end

  // Write responder: accept AW+W, hold B until bready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_hs) begin
          bvalid_q  <= 1'b1;
          bresp_q   <= idx_mapped(aw_idx) ? RESP_OKAY : RESP_SLVERR;
          w_state_q <= W_RESP;
        end
        W_RESP: if (bus.bready) begin
          bvalid_q  <= 1'b0;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read responder: capture data on AR, hold R until rready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (ar_hs) begin
          rvalid_q  <= 1'b1;
          rresp_q   <= idx_mapped(ar_idx) ? RESP_OKAY : RESP_SLVERR;
          rdata_q   <= rd_val;
          r_state_q <= R_RESP;
        end
        R_RESP: if (bus.rready) begin
          rvalid_q  <= 1'b0;
          r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign bus.bvalid = bvalid_q;
  assign bus.bresp  = bresp_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rresp  = rresp_q;
  assign bus.rdata  = rdata_q;

  assign irq = match_flag && ctrl[2];

endmodule

// File: tb/tb_axi4_lite_timer.sv
// Randomized bench for axi4_lite_timer against a cycle-level register model.
module tb_axi4_lite_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  axi4_lite_timer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers plus prescale phase
  bit [31:0]   m_cnt, m_cmp;
  bit [15:0]   m_pre;
  int unsigned m_phase;
  bit          m_en, m_ar, m_ie, m_flag;

  function automatic void m_reset();
    m_cnt = 0; m_cmp = 0; m_pre = 0; m_phase = 0;
    m_en = 0; m_ar = 0; m_ie = 0; m_flag = 0;
  endfunction

  function automatic bit [31:0] m_read(input int idx);
    case (idx)
      0: return {29'd0, m_ie, m_ar, m_en};
      1: return {31'd0, m_flag};
      2: return m_cnt;
      3: return m_cmp;
      4: return {16'd0, m_pre};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit [31:0] m_merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] s);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // True when the coming edge is a tick with COUNT==COMPARE
  function automatic bit m_hit_next();
    return m_en && (m_phase == m_pre) && (m_cnt == m_cmp);
  endfunction

  // Advance model and DUT by one clock edge; we/idx/d/s describe a write accepted at this edge
  task automatic step(input bit we, input int idx, input bit [31:0] d, input bit [3:0] s);
    bit        tick, hit;
    bit [31:0] old_cnt, nv;
    tick    = m_en && (m_phase == m_pre);
    hit     = tick && (m_cnt == m_cmp);
    old_cnt = m_cnt;
    if (tick) m_cnt = (hit && m_ar) ? 32'd0 : m_cnt + 32'd1;
    m_phase = (!m_en || tick) ? 0 : m_phase + 1;
    if (we) begin
      case (idx)
        0: if (s[0]) {m_ie, m_ar, m_en} = d[2:0];
        1: if (s[0] && d[0]) m_flag = 0;
        2: m_cnt = m_merge(old_cnt, d, s);
        3: m_cmp = m_merge(m_cmp, d, s);
        4: begin nv = m_merge({16'd0, m_pre}, d, s); m_pre = nv[15:0]; m_phase = 0; end
        default: ;
      endcase
    end
    if (hit) m_flag = 1;
    @(posedge clk); #1;
    chk("irq", {31'd0, irq}, {31'd0, m_flag & m_ie});
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic axi_write(input bit [31:0] addr, input bit [31:0] d, input bit [3:0] s, input int bdly);
    int idx;
    bit mapped;
    idx = int'(addr[4:2]);
    mapped = (idx <= 4);
    bus.awaddr = addr; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1; bus.wvalid = 1;
    #1;
    chk("awready", {31'd0, bus.awready}, 32'd1);
    chk("wready", {31'd0, bus.wready}, 32'd1);
    step(mapped, idx, d, s);
    bus.awvalid = 0; bus.wvalid = 0;
    chk("bvalid", {31'd0, bus.bvalid}, 32'd1);
    chk("bresp", {30'd0, bus.bresp}, mapped ? 32'd0 : 32'd2);
    for (int i = 0; i < bdly; i++) begin
      step(0, 0, 0, 0);
      chk("bvalid_hold", {31'd0, bus.bvalid}, 32'd1);
      chk("bresp_hold", {30'd0, bus.bresp}, mapped ? 32'd0 : 32'd2);
    end
    bus.bready = 1;
    step(0, 0, 0, 0);
    bus.bready = 0;
    chk("bvalid_clr", {31'd0, bus.bvalid}, 32'd0);
  endtask

  task automatic axi_read(input bit [31:0] addr, input int rdly, output bit [31:0] got);
    int        idx;
    bit [31:0] exp;
    bit [31:0] rsp;
    idx = int'(addr[4:2]);
    exp = m_read(idx);
    rsp = (idx <= 4) ? 32'd0 : 32'd2;
    bus.araddr = addr; bus.arvalid = 1;
    #1;
    chk("arready", {31'd0, bus.arready}, 32'd1);
    step(0, 0, 0, 0);
    bus.arvalid = 0;
    chk("rvalid", {31'd0, bus.rvalid}, 32'd1);
    chk("rdata", bus.rdata, exp);
    chk("rresp", {30'd0, bus.rresp}, rsp);
    got = bus.rdata;
    for (int i = 0; i < rdly; i++) begin
      step(0, 0, 0, 0);
      chk("rvalid_hold", {31'd0, bus.rvalid}, 32'd1);
      chk("rdata_hold", bus.rdata, exp);
      chk("rresp_hold", {30'd0, bus.rresp}, rsp);
    end
    bus.rready = 1;
    step(0, 0, 0, 0);
    bus.rready = 0;
    chk("rvalid_clr", {31'd0, bus.rvalid}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, {31'd0, bus.awready}, 32'd0);
    chk({tag, "_wready"},  {31'd0, bus.wready},  32'd0);
    chk({tag, "_arready"}, {31'd0, bus.arready}, 32'd0);
    chk({tag, "_bvalid"},  {31'd0, bus.bvalid},  32'd0);
    chk({tag, "_rvalid"},  {31'd0, bus.rvalid},  32'd0);
    chk({tag, "_bresp"},   {30'd0, bus.bresp},   32'd0);
    chk({tag, "_rresp"},   {30'd0, bus.rresp},   32'd0);
    chk({tag, "_rdata"},   bus.rdata,            32'd0);
    chk({tag, "_irq"},     {31'd0, irq},         32'd0);
  endtask

  initial begin
    bit [31:0] got, d;
    bit        found;
    int        op, idx;

    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
    m_reset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 0;
    axi_read(32'h00, 0, got);
    chk("ctrl_after_por", got, 32'd0);

    // Byte strobes on COMPARE
    axi_write(32'h0C, 32'hAABB_CCDD, 4'b0101, 0);
    axi_read(32'h0C, 0, got);
    chk("cmp_strobe", got, 32'h00BB_00DD);

    // Auto-reload match with irq
    axi_write(32'h10, 32'h0, 4'hF, 0);
    axi_write(32'h0C, 32'h3, 4'hF, 0);
    axi_write(32'h08, 32'h0, 4'hF, 1);
    axi_write(32'h00, 32'h7, 4'hF, 0);
    for (int i = 0; i < 4; i++) axi_read(32'h08, i & 1, got);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (irq) found = 1; else step(0, 0, 0, 0);
    end
    chk("irq_seen", {31'd0, found}, 32'd1);
    axi_write(32'h00, 32'h4, 4'hF, 0);
    axi_write(32'h04, 32'h1, 4'hF, 0);
    chk("irq_w1c", {31'd0, irq}, 32'd0);

    // Prescale and wrap
    axi_write(32'h00, 32'h0, 4'hF, 0);
    axi_write(32'h10, 32'h2, 4'hF, 0);
    axi_write(32'h0C, 32'h5, 4'hF, 0);
    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0);
    axi_write(32'h00, 32'h1, 4'hF, 0);
    for (int i = 0; i < 6; i++) axi_read(32'h08, i % 3, got);

    // Unmapped accesses with backpressure
    axi_read(32'h18, 4, got);
    chk("unmapped_rdata", got, 32'd0);
    axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, 2);
    axi_write(32'h1C, 32'h1234_5678, 4'hF, 0);
    for (int i = 0; i < 5; i++) axi_read(32'(i * 4), 0, got);

    // COUNT write on a tick cycle: software value wins
    axi_write(32'h00, 32'h0, 4'hF, 0);
    axi_write(32'h10, 32'h0, 4'hF, 0);
    axi_write(32'h0C, 32'h100, 4'hF, 0);
    axi_write(32'h00, 32'h1, 4'hF, 0);
    axi_write(32'h08, 32'h10, 4'hF, 0);
    axi_read(32'h08, 0, got);

    // W1C on the cycle the match sets: set wins
    axi_write(32'h00, 32'h0, 4'hF, 0);
    axi_write(32'h0C, 32'h40, 4'hF, 0);
    axi_write(32'h08, 32'h30, 4'hF, 0);
    axi_write(32'h04, 32'h1, 4'hF, 0);
    axi_write(32'h00, 32'h5, 4'hF, 0);
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_hit_next()) found = 1; else step(0, 0, 0, 0);
    end
    chk("hit_reached", {31'd0, found}, 32'd1);
    axi_write(32'h04, 32'h1, 4'hF, 0);
    chk("w1c_set_wins", {31'd0, irq}, 32'd1);
    axi_read(32'h04, 0, got);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      op  = $urandom_range(0, 9);
      idx = (op < 8 && $urandom_range(0, 5) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      d   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 12);
      if (op < 5)      axi_write(32'(idx * 4), d, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      else if (op < 8) axi_read(32'(idx * 4), $urandom_range(0, 3), got);
      else             idle($urandom_range(1, 5));
    end

    // Reset in the middle of a write response, with a read pending
    axi_write(32'h00, 32'h0, 4'hF, 0);
    bus.awaddr = 32'h0C; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    #1;
    step(1, 3, 32'h55, 4'hF);
    chk("pre_rst_bvalid", {31'd0, bus.bvalid}, 32'd1);
    bus.araddr = 32'h08; bus.arvalid = 1;
    rst = 1;
    #1;
    chk_reset_outputs("midrst");
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    @(posedge clk); #1;
    rst = 0;
    m_reset();
    idle(2);
    chk("post_rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
    chk("post_rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    axi_read(32'h00, 0, got);
    chk("ctrl_after_rst", got, 32'd0);
    axi_read(32'h0C, 0, got);
    chk("cmp_after_rst", got, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi4_lite_timer.md
# axi4_lite_timer

Memory-mapped 32-bit timer/compare peripheral that terminates AXI4-Lite directly as a native responder, with no generic slave adapter in between. It sits on one interconnect slave port beside the data memories and LED. It provides a programmable prescaler, a free-running or auto-reload counter, a compare-match flag and a level interrupt to the core.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width; only addr[4:2] are decoded, because the interconnect has already selected this slave.
- DATA_WIDTH, 32, AXI data width; fixed at 32.

Ports:
- clk  input  1  single clock
- rst  input  1  asynchronous, active-high reset
- awaddr, awvalid, awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- wdata, wstrb, wvalid, wready  in/in/in/out  32/4/1/1  write data channel
- bresp, bvalid, bready  out/out/in  2/1/1  write response channel
- araddr, arvalid, arready  in/in/out  ADDR_WIDTH/1/1  read address channel
- rdata, rresp, rvalid, rready  out/out/out/in  32/2/1/1  read data channel
- irq  output  1  match_flag & CTRL.irq_en

## Operation
Register map (offsets):
- 0x00 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
- 0x04 STATUS: bit0 match_flag; write-1-to-clear.
- 0x08 COUNT: RW.
- 0x0C COMPARE: RW.
- 0x10 PRESCALE: RW, bits[15:0] only.
- 0x14–0x1C: unmapped. A write has no effect and returns bresp=SLVERR (2'b10). A read returns rdata=0 and rresp=SLVERR.

Write path:
- States W_IDLE and W_RESP.
- In W_IDLE, awready and wready are both high only while awvalid & wvalid are both high, so address and data are accepted together.
- On acceptance, the register is updated per wstrb byte lane and the FSM moves to W_RESP.
- In W_RESP, bvalid is held with OKAY or SLVERR until bready, then the FSM returns to W_IDLE.

Read path:
- States R_IDLE and R_RESP, independent of the write path.
- arready is high in R_IDLE.
- On handshake, rdata and rresp are registered and the FSM moves to R_RESP.
- rvalid is held until rready.

Counter:
- When enable=1, the prescale counter counts 0..PRESCALE. On reaching PRESCALE it issues a one-cycle tick and returns to 0. PRESCALE=0 gives a tick every cycle.
- On a tick with COUNT==COMPARE:
  - match_flag is set.
  - COUNT becomes 0 if auto_reload=1; otherwise it increments.
- On any other tick, COUNT increments, wrapping 0xFFFFFFFF→0.
- When enable=0, the prescale counter holds at 0 and COUNT holds.

Simultaneous events:
- A software write to COUNT in the same cycle as a tick: the software value wins.
- A W1C of match_flag in the same cycle as a set: the set wins.
- A write to PRESCALE resets the prescale counter to 0.

## Timing
- Reset values: all registers 0; awready, wready, arready, bvalid, rvalid, irq at 0; bresp, rresp, rdata at 0. Both FSMs start in IDLE.
- Reset asserted mid-transaction aborts it immediately; no response is issued after reset releases.
- Write: AW/W handshake at edge N. The register takes its new value at edge N. bvalid is high from cycle N+1. Earliest back-to-back acceptance is one cycle after the B handshake.
- Read: AR handshake at edge N; rvalid and rdata are valid in cycle N+1. rdata reflects register state sampled at edge N.
- A read and a write to the same register in the same cycle: the read returns the old value.
- Match: a tick at edge N with COUNT==COMPARE sets match_flag at edge N. irq is combinational from match_flag and irq_en, so it rises in cycle N+1.
- Responses hold stable while valid and ready is low.

## Structure
- Extend axi4_lite_addr_map_package with:
  - TIMER register offset constants.
  - RESP_OKAY / RESP_SLVERR localparams.
  - Write-FSM and read-FSM state enum typedefs.
- One sub-module, axi4_lite_timer_core, holds the prescaler, COUNT, compare and match_flag logic. It takes register write strobes from the bus FSMs.
- The top gets a new SLAVE_NUM entry, base address and mask.

## Test plan
- Reset: assert rst mid-write → all outputs 0, FSMs in IDLE; read CTRL after release → 0x0, OKAY.
- Byte strobes: write 0xAABBCCDD to COMPARE with wstrb=0b0101, starting from 0 → readback 0x00BB00DD, bresp OKAY, bvalid one cycle after handshake.
- Auto-reload match: PRESCALE=0, COMPARE=3, CTRL=0b111 → COUNT sequence 0,1,2,3,0; irq rises the cycle after the tick at COUNT==3; W1C STATUS=1 → irq low.
- Prescale and wrap: PRESCALE=2, COUNT=0xFFFFFFFF, enable, no auto_reload → COUNT becomes 0 after 3 cycles and increments every 3 cycles.
- Unmapped and backpressure: read 0x18 with rready low for 4 cycles → rvalid held, rdata=0, rresp=2'b10 stable until rready; write to 0x14 → SLVERR, no register changes.
- Collisions: software write COUNT=0x10 on a tick cycle → COUNT=0x10; W1C on a set cycle → match_flag stays 1.
